// File: rtl/fixed_mac_pe.sv
// Pipelined fixed-point MAC processing element: multiplies Q-format operand pairs,
// accumulates KERNEL_LEN products per window and emits one saturated result per window.
module fixed_mac_pe #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 13,
  parameter int ACC_WIDTH  = 24,
  parameter int KERNEL_LEN = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  sat
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(KERNEL_LEN - 1);

  logic signed [PROD_WIDTH-1:0] prodFull;
  logic signed [PROD_WIDTH-1:0] prodShift;
  logic signed [ACC_WIDTH-1:0]  prodExt;
  logic signed [ACC_WIDTH-1:0]  prodReg;
  logic                         pValid;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic signed [ACC_WIDTH-1:0]  sum;
  logic [CNT_WIDTH-1:0]         cnt;
  logic                         lastCnt;
  logic                         satHi;
  logic                         satLo;
  logic [DATA_WIDTH-1:0]        satVal;
  logic                         accept;
  logic                         windowDone;

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // a producer holds its payload stable while valid & ~ready, and ready never depends
  // on the partner's valid. in_ready only drops while a finished result is unclaimed.
  assign in_ready = ~(out_valid & ~out_ready);
  assign accept   = in_valid & in_ready;

  // Arithmetic shift floors the Q-format product; the size cast sign-extends or truncates.
  assign prodFull  = $signed(a) * $signed(b);
  assign prodShift = prodFull >>> FRAC_BITS;
  assign prodExt   = ACC_WIDTH'(prodShift);

  assign sum        = acc + prodReg;
  assign lastCnt    = (cnt == LAST_CNT);
  assign windowDone = pValid & ~clear & lastCnt;
  assign satHi      = (sum > SAT_MAX);
  assign satLo      = (sum < SAT_MIN);

  always_comb begin
    satVal = sum[DATA_WIDTH-1:0];
    if (satHi) begin
      satVal = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (satLo) begin
      satVal = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pValid  <= 1'b0;
      prodReg <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else if (clear) begin
      // Abort drops the partial window and any product still in flight.
      pValid <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      pValid <= accept;
      if (accept) begin
        prodReg <= prodExt;
      end
      if (pValid) begin
        if (lastCnt) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  // The result register is untouched by clear so an unclaimed result survives an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      sat       <= 1'b0;
    end else if (windowDone) begin
      out_valid <= 1'b1;
      result    <= satVal;
      sat       <= satHi | satLo;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fixed_mac_pe.sv
// Self-checking bench for fixed_mac_pe: directed windows plus random streams checked
// against a window-level arithmetic model with an expected-result queue.
module tb_fixed_mac_pe;

  localparam int DW = 16;
  localparam int FB = 13;
  localparam int AW = 24;
  localparam int KL = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [DW-1:0] a = '0;
  logic [DW-1:0] b = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] result;
  logic          sat;

  fixed_mac_pe #(
    .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(AW), .KERNEL_LEN(KL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .sat(sat)
  );

  // clock / reset
  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  int  cyc = 0;
  bit  in_rst = 1'b1;
  bit  rand_on = 1'b0;

  logic [DW:0] exp_q[$];
  int          due_q[$];
  logic [DW:0] hs_q[$];
  int          hs_cyc[$];

  longint m_sum = 0;
  int     m_cnt = 0;
  bit     m_fly = 1'b0;
  longint m_prod = 0;
  int     stall_cnt = 0;
  int     acc_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // reference model helpers
  function automatic longint wrap_acc(input longint v);
    longint m;
    longint r;
    m = longint'(1) << AW;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic longint prod_ref(input logic [DW-1:0] x, input logic [DW-1:0] y);
    longint p;
    longint d;
    longint q;
    p = longint'($signed(x)) * longint'($signed(y));
    d = longint'(1) << FB;
    q = p / d;
    if ((p % d != 0) && (p < 0)) q -= 1;
    return wrap_acc(q);
  endfunction

  function automatic logic [DW:0] sat_ref(input longint s);
    longint hi;
    hi = (longint'(1) << (DW - 1)) - 1;
    if (s > hi) return {1'b1, 1'b0, {(DW-1){1'b1}}};
    if (s < -hi - 1) return {1'b1, 1'b1, {(DW-1){1'b0}}};
    return {1'b0, DW'(s)};
  endfunction

  // scoreboard and model step, evaluated on the falling edge for the coming rising edge
  always @(negedge clk) begin
    if (!in_rst) begin
      logic want_ov;
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (!in_ready) stall_cnt++;
      want_ov = (exp_q.size() > 0) && (due_q[0] <= cyc);
      chk("out_valid", 32'(out_valid), 32'(want_ov));
      if (out_valid && exp_q.size() > 0) chk("result", 32'({sat, result}), 32'(exp_q[0]));
      if (out_valid && out_ready) begin
        hs_q.push_back({sat, result});
        hs_cyc.push_back(cyc);
        if (exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          void'(due_q.pop_front());
        end
      end
      if (in_valid && in_ready) acc_cnt++;
      if (clear) begin
        m_sum = 0;
        m_cnt = 0;
        m_fly = 1'b0;
      end else begin
        if (m_fly) begin
          m_sum = wrap_acc(m_sum + m_prod);
          m_cnt++;
          if (m_cnt == KL) begin
            exp_q.push_back(sat_ref(m_sum));
            due_q.push_back(cyc + 1);
            m_sum = 0;
            m_cnt = 0;
          end
        end
        m_fly = in_valid && in_ready;
        if (m_fly) m_prod = prod_ref(a, b);
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] x, input logic [DW-1:0] y);
    int w;
    in_valid = 1'b1;
    a = x;
    b = y;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: in_ready stuck at %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    idle(2);
    w = 0;
    while ((exp_q.size() > 0 || out_valid) && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic chk_hs(input string nm, input int idx, input logic [DW:0] exp);
    if (hs_q.size() > idx) chk(nm, 32'(hs_q[idx]), 32'(exp));
    else chk({nm, "_missing"}, 32'(hs_q.size()), 32'(idx + 1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int a0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    in_rst = 1'b0;

    // positive saturation, then in-range window
    hs_q.delete();
    repeat (KL) send(16'h2000, 16'h2000);
    repeat (KL) send(16'h2000, 16'h0400);
    drain();
    chk_hs("sat_pos", 0, 17'h1_7FFF);
    chk_hs("plain_pos", 1, 17'h0_2000);

    // floor rounding and negative saturation
    hs_q.delete();
    repeat (KL) send(16'hFFFF, 16'h0001);
    repeat (KL) send(16'hE000, 16'h6000);
    drain();
    chk_hs("floor_neg", 0, 17'h0_FFF8);
    chk_hs("sat_neg", 1, 17'h1_8000);

    // back-pressure for five cycles after the first result
    hs_q.delete();
    stall_cnt = 0;
    a0 = acc_cnt;
    fork
      begin
        repeat (2 * KL) send(DW'($urandom), DW'($urandom));
      end
      begin
        int w;
        w = 0;
        while (!out_valid && w < 100) begin
          @(posedge clk);
          #1;
          w++;
        end
        out_ready = 1'b0;
        repeat (5) begin
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_stall_cycles", 32'(stall_cnt), 32'd5);
    chk("bp_results", 32'(hs_q.size()), 32'd2);
    chk("bp_accepted", 32'(acc_cnt - a0), 32'(2 * KL));

    // four back-to-back windows
    hs_q.delete();
    hs_cyc.delete();
    c0 = cyc;
    repeat (4 * KL) send(DW'($urandom), DW'($urandom));
    chk("b2b_cycles", 32'(cyc - c0), 32'(4 * KL));
    drain();
    chk("b2b_results", 32'(hs_q.size()), 32'd4);
    for (int i = 1; i < 4; i++) begin
      if (hs_cyc.size() > i) chk("b2b_spacing", 32'(hs_cyc[i] - hs_cyc[i-1]), 32'(KL));
    end

    // clear mid-window; the operand offered during clear is dropped too
    hs_q.delete();
    repeat (3) send(DW'($urandom), DW'($urandom));
    pulse_clear();
    repeat (KL) send(16'h0400, 16'h2000);
    drain();
    chk("clear_results", 32'(hs_q.size()), 32'd1);
    chk_hs("clear_window", 0, 17'h0_2000);

    // pending result survives clear
    hs_q.delete();
    out_ready = 1'b0;
    repeat (KL + 1) send(16'h2000, 16'h0400);
    idle(2);
    pulse_clear();
    idle(3);
    chk("pend_valid", 32'(out_valid), 32'd1);
    chk("pend_result", 32'({sat, result}), 32'h0_2000);
    out_ready = 1'b1;
    drain();
    chk("pend_results", 32'(hs_q.size()), 32'd1);

    // asynchronous reset mid-window with a held result
    out_ready = 1'b0;
    repeat (KL + 1) send(DW'($urandom), DW'($urandom));
    idle(1);
    #2;
    chk("pre_areset_valid", 32'(out_valid), 32'd1);
    in_rst = 1'b1;
    reset = 1'b0;
    #1;
    chk("areset_out_valid", 32'(out_valid), 32'd0);
    chk("areset_result", 32'(result), 32'd0);
    chk("areset_sat", 32'(sat), 32'd0);
    chk("areset_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    due_q.delete();
    m_sum = 0;
    m_cnt = 0;
    m_fly = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    in_rst = 1'b0;
    out_ready = 1'b1;
    hs_q.delete();
    repeat (KL) send(16'h0800, 16'h2000);
    drain();
    chk_hs("post_reset", 0, 17'h0_4000);

    // random stream with random gaps and random back-pressure
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 6 * KL; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
          send(DW'($urandom), DW'($urandom));
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
